grf_wb_arbiter: RTL and testbench

Write-port arbiter for the 32×32 general register file (`grf`). It shares the GRF's single write port between two writeback sources: source 0 is the pipeline WB stage and source 1 is the multi-cycle unit, such as mult/div result return. Arbitration is fixed-priority to source 0 with a starvation escape for source 1. The winning request is registered and driven onto `grf`'s `WE/wt/wdata/wPc` one cycle after acceptance.

---
 rtl/grf_pkg.sv | 27 ++
 rtl/grf_wb_arbiter_out_reg.sv | 38 +++
 rtl/grf_wb_arbiter.sv | 121 ++++++++++++
 tb/tb_grf_wb_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// Shared definitions for the GRF write path: widths, the writeback request
// bundle and the arbiter state encoding.
package grf_pkg;

    localparam int GRF_AW = 5;
    localparam int GRF_DW = 32;
    localparam int PC_W   = 32;

    localparam logic [GRF_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [GRF_AW-1:0] wt;
        logic [GRF_DW-1:0] wdata;
        logic [PC_W-1:0]   wPc;
    } wb_req_t;

    typedef enum logic {
        PRI0   = 1'b0,
        FORCE1 = 1'b1
    } arb_state_e;

    // $0 is hardwired to zero, so a request aimed at it must never assert WE.
    function automatic logic writes_reg(input logic [GRF_AW-1:0] dst);
        return dst != REG_ZERO;
    endfunction

endpackage

// File: rtl/grf_wb_arbiter_out_reg.sv
// Registered writeback output stage with $0 filtering and synchronous clear.
// The write strobe is additionally masked while reset is high so a request
// accepted just before reset never reaches the register file.
module wb_out_reg
    import grf_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  wb_req_t           req,
    output logic              WE,
    output logic [GRF_AW-1:0] wt,
    output logic [GRF_DW-1:0] wdata,
    output logic [PC_W-1:0]   wPc
);

    logic    we_q;
    wb_req_t req_q;

    // Capture the accepted request; the payload holds when nothing is accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q  <= 1'b0;
            req_q <= '0;
        end else if (load) begin
            we_q  <= writes_reg(req.wt);
            req_q <= req;
        end else begin
            we_q  <= 1'b0;
        end
    end

    assign WE    = we_q & ~reset;
    assign wt    = req_q.wt;
    assign wdata = req_q.wdata;
    assign wPc   = req_q.wPc;

endmodule

// File: rtl/grf_wb_arbiter.sv
// Write-port arbiter for the GRF. Source 0 (pipeline WB) has fixed priority;
// source 1 (multi-cycle unit) is forced through after STARVE_LIMIT consecutive
// blocked cycles. The winner is registered onto WE/wt/wdata/wPc.
//
// state  | meaning
// -------+-------------------------------------------------------------
// PRI0   | normal operation, source 0 wins any contention
// FORCE1 | source 1 has starved; it alone may be accepted this cycle
module grf_wb_arbiter
    import grf_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [GRF_AW-1:0] s0_wt,
    input  logic [GRF_DW-1:0] s0_wdata,
    input  logic [PC_W-1:0]   s0_wPc,

    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [GRF_AW-1:0] s1_wt,
    input  logic [GRF_DW-1:0] s1_wdata,
    input  logic [PC_W-1:0]   s1_wPc,

    output logic              WE,
    output logic [GRF_AW-1:0] wt,
    output logic [GRF_DW-1:0] wdata,
    output logic [PC_W-1:0]   wPc,
    output logic              force1
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    arb_state_e       state;
    arb_state_e       state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] cnt_next;

    logic             load;
    wb_req_t          req_sel;

    // State and starvation counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= PRI0;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= cnt_next;
        end
    end

    // Grant decode, starvation count and next-state logic.
    always_comb begin
        s0_ready   = 1'b0;
        s1_ready   = 1'b0;
        state_next = state;
        cnt_next   = wait_cnt;

        // Both readys stay low during reset so nothing is accepted that cycle.
        if (!reset) begin
            unique case (state)
                PRI0: begin
                    s0_ready = s0_valid;
                    s1_ready = s1_valid && !s0_valid;
                end
                FORCE1: begin
                    s1_ready = s1_valid;
                end
                default: ;
            endcase
        end

        if (!s1_valid || s1_ready) begin
            cnt_next = '0;
        end else if (wait_cnt != LIMIT_C) begin
            cnt_next = wait_cnt + 1'b1;
        end

        unique case (state)
            PRI0: begin
                if (cnt_next == LIMIT_C && wait_cnt != LIMIT_C) begin
                    state_next = FORCE1;
                end
            end
            FORCE1: begin
                // Leaves on acceptance, or on a protocol-violating withdrawal.
                if (s1_ready || !s1_valid) begin
                    state_next = PRI0;
                end
            end
            default: state_next = PRI0;
        endcase
    end

    // Payload mux: at most one ready is high, so s1_ready alone selects.
    always_comb begin
        req_sel = s1_ready ? wb_req_t'{wt: s1_wt, wdata: s1_wdata, wPc: s1_wPc}
                           : wb_req_t'{wt: s0_wt, wdata: s0_wdata, wPc: s0_wPc};
    end

    assign load   = s0_ready | s1_ready;
    assign force1 = (state == FORCE1);

    wb_out_reg u_out (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .req   (req_sel),
        .WE    (WE),
        .wt    (wt),
        .wdata (wdata),
        .wPc   (wPc)
    );

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Scoreboard bench for grf_wb_arbiter: a driver applies stimulus and pushes
// the expected per-cycle response and expected commits; a monitor compares.
module tb_grf_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        s0_valid, s1_valid;
    logic        s0_ready, s1_ready;
    logic [4:0]  s0_wt, s1_wt;
    logic [31:0] s0_wdata, s1_wdata, s0_wPc, s1_wPc;
    logic        WE, force1;
    logic [4:0]  wt;
    logic [31:0] wdata, wPc;

    grf_wb_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s0_wt    (s0_wt),
        .s0_wdata (s0_wdata),
        .s0_wPc   (s0_wPc),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .s1_wt    (s1_wt),
        .s1_wdata (s1_wdata),
        .s1_wPc   (s1_wPc),
        .WE       (WE),
        .wt       (wt),
        .wdata    (wdata),
        .wPc      (wPc),
        .force1   (force1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          s0r;
        bit          s1r;
        bit          we;
        bit          f1;
        logic [4:0]  wt;
        logic [31:0] wdata;
        logic [31:0] wpc;
    } cyc_t;

    typedef struct {
        logic [4:0]  wt;
        logic [31:0] wdata;
        logic [31:0] wpc;
    } commit_t;

    cyc_t    cyc_q[$];
    commit_t commit_q[$];

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: s1 has waited `blocked` consecutive cycles without a
    // grant; once that reaches LIMIT it owns the port for the next cycle.
    int          blocked = 0;
    bit          m_we    = 0;
    logic [4:0]  m_wt    = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_wpc   = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    task automatic drive(input bit rst,
                         input bit v0, input logic [4:0] wt0, input logic [31:0] d0, input logic [31:0] pc0,
                         input bit v1, input logic [4:0] wt1, input logic [31:0] d1, input logic [31:0] pc1,
                         output bit a0, output bit a1);
        cyc_t    e;
        commit_t c;
        bit      starved;
        @(posedge clk);
        #1;
        reset = rst;
        s0_valid = v0; s0_wt = wt0; s0_wdata = d0; s0_wPc = pc0;
        s1_valid = v1; s1_wt = wt1; s1_wdata = d1; s1_wPc = pc1;

        starved = (blocked >= LIMIT);
        a0 = 0;
        a1 = 0;
        if (!rst) begin
            if (starved)  a1 = v1;
            else if (v0)  a0 = 1;
            else          a1 = v1;
        end

        e.s0r = a0; e.s1r = a1; e.f1 = starved;
        e.we = m_we && !rst;
        e.wt = m_wt; e.wdata = m_wdata; e.wpc = m_wpc;
        cyc_q.push_back(e);
        if (e.we) begin
            c.wt = m_wt; c.wdata = m_wdata; c.wpc = m_wpc;
            commit_q.push_back(c);
        end

        if (rst) begin
            blocked = 0;
            m_we = 0; m_wt = '0; m_wdata = '0; m_wpc = '0;
        end else begin
            blocked = (a1 || !v1) ? 0 : blocked + 1;
            if (a0) begin
                m_we = (wt0 != 0); m_wt = wt0; m_wdata = d0; m_wpc = pc0;
            end else if (a1) begin
                m_we = (wt1 != 0); m_wt = wt1; m_wdata = d1; m_wpc = pc1;
            end else begin
                m_we = 0;
            end
        end
    endtask

    task automatic idle(input bit rst, input int n);
        bit a0, a1;
        for (int i = 0; i < n; i++)
            drive(rst, 0, '0, '0, '0, 0, '0, '0, '0, a0, a1);
    endtask

    // Monitor: per-cycle response and in-order commit checking.
    always @(negedge clk) begin
        cyc_t    e;
        commit_t c;
        if (cyc_q.size() > 0) begin
            e = cyc_q.pop_front();
            check("s0_ready", {31'b0, s0_ready}, {31'b0, e.s0r});
            check("s1_ready", {31'b0, s1_ready}, {31'b0, e.s1r});
            check("WE",       {31'b0, WE},       {31'b0, e.we});
            check("force1",   {31'b0, force1},   {31'b0, e.f1});
            check("wt",       {27'b0, wt},       {27'b0, e.wt});
            check("wdata",    wdata,             e.wdata);
            check("wPc",      wPc,               e.wpc);
            if (WE === 1'b1) begin
                if (commit_q.size() == 0) begin
                    check("commit_unexpected", 32'd1, 32'd0);
                end else begin
                    c = commit_q.pop_front();
                    check("commit_wt",    {27'b0, wt}, {27'b0, c.wt});
                    check("commit_wdata", wdata,       c.wdata);
                end
            end
        end
    end

    initial begin
        bit          a0, a1;
        bit          v0, v1;
        logic [4:0]  wt0, wt1;
        logic [31:0] d0, d1, pc0, pc1;
        int          k0, k1;

        reset = 1'b1;
        s0_valid = 0; s1_valid = 0;
        s0_wt = '0; s1_wt = '0; s0_wdata = '0; s1_wdata = '0; s0_wPc = '0; s1_wPc = '0;
        @(posedge clk);

        // Reset then idle.
        idle(1, 2);
        idle(0, 3);

        // Single s1 write.
        drive(0, 0, '0, '0, '0, 1, 5'd3, 32'h20, 32'h3004, a0, a1);
        idle(0, 2);

        // $0 write from s0.
        drive(0, 1, 5'd0, 32'hFFFF_FFFF, 32'h3008, 0, '0, '0, '0, a0, a1);
        idle(0, 2);

        // Contention: both held high; new payload after each acceptance.
        k0 = 1; k1 = 1;
        for (int i = 0; i < 14; i++) begin
            drive(0, 1, 5'(k0), 32'h100 + 32'(k0), 32'h4000 + 32'(k0 * 4),
                     1, 5'(16 + k1), 32'h200 + 32'(k1), 32'h5000 + 32'(k1 * 4), a0, a1);
            if (a0) k0++;
            if (a1) k1++;
        end
        idle(0, 2);

        // Reset mid-operation.
        drive(0, 1, 5'd7, 32'hDEAD_BEEF, 32'h6000, 0, '0, '0, '0, a0, a1);
        idle(1, 1);
        idle(0, 2);

        // Withdrawal in FORCE1.
        for (int i = 0; i < LIMIT; i++)
            drive(0, 1, 5'(8 + i), 32'h300 + 32'(i), 32'h7000, 1, 5'd20, 32'h400, 32'h7100, a0, a1);
        drive(0, 1, 5'd12, 32'h304, 32'h7000, 0, '0, '0, '0, a0, a1);
        drive(0, 1, 5'd12, 32'h304, 32'h7000, 0, '0, '0, '0, a0, a1);
        idle(0, 2);

        // Randomized, protocol-respecting traffic with occasional reset.
        v0 = 0; v1 = 0;
        wt0 = '0; wt1 = '0; d0 = '0; d1 = '0; pc0 = '0; pc1 = '0;
        for (int i = 0; i < 500; i++) begin
            bit rst;
            if (!v0 && $urandom_range(0, 99) < 60) begin
                v0 = 1; wt0 = 5'($urandom); d0 = $urandom; pc0 = $urandom;
            end
            if (!v1 && $urandom_range(0, 99) < 55) begin
                v1 = 1; wt1 = 5'($urandom); d1 = $urandom; pc1 = $urandom;
            end
            rst = ($urandom_range(0, 99) < 2);
            drive(rst, v0, wt0, d0, pc0, v1, wt1, d1, pc1, a0, a1);
            if (a0) v0 = 0;
            if (a1) v1 = 0;
        end
        idle(0, 3);

        @(posedge clk);
        #1;
        check("commit_queue_drained", 32'(commit_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
